sram_like_arbiter: RTL and testbench

- Shares one SRAM-like slave port between two SRAM-like masters: the instruction-fetch port (inst) and the load/store port (data).
- Sits between the CPU pipeline and the SRAM-like-to-AXI bridge.
- Grants one address transfer at a time and holds the grant until addrok.
- Records the owner of every accepted request, in order, so each in-order dataok and rdata reaches the correct master.

---
 rtl/sram_like_arbiter_pkg.sv | 11 +
 rtl/sram_like_arbiter_if.sv | 16 +
 rtl/sram_like_arbiter_owner_fifo.sv | 51 +++++
 rtl/sram_like_arbiter.sv | 71 +++++++
 tb/tb_sram_like_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like two-master arbiter: bus widths,
// owner encodings and the grant state type.
package sram_like_arbiter_pkg;
  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int SIZE_W          = 2;
  localparam int OUTSTANDING_DEF = 4;

  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;
  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} grant_st_e;
endpackage

// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like port. The master drives request fields; the slave answers
// with addrok/dataok/rdata.
interface sram_like_arbiter_if;
  import sram_like_arbiter_pkg::*;
  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addrok;
  logic              dataok;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr, size, addr, wdata, input addrok, dataok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addrok, dataok, rdata);
endinterface

// File: rtl/sram_like_arbiter_owner_fifo.sv
// 1-bit-wide owner FIFO: remembers which master issued each accepted request
// so in-order responses can be routed back.
module sram_like_arbiter_owner_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_head,
  output logic o_full,
  output logic o_empty
);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == CNT_MAX);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  // A pop on empty is a spurious return and must not disturb the pointers.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave between the inst and data masters. Data wins when
// free; a grant the slave has seen is held until addrok. Returns are in order.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEF,
  parameter int PTR_W       = $clog2(OUTSTANDING)
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_like_arbiter_if.slave   inst,
  sram_like_arbiter_if.slave   data,
  sram_like_arbiter_if.master  bus
);
  grant_st_e r_state, w_state_nxt;
  owner_e    r_owner, w_owner_nxt, w_sel;
  logic      w_sel_req, w_accept;
  logic      w_full, w_empty, w_head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_UNLOCKED;
      r_owner <= OWN_INST;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_sel       = (r_state == ST_LOCKED) ? r_owner : (data.req ? OWN_DATA : OWN_INST);
    w_sel_req   = (w_sel == OWN_DATA) ? data.req : inst.req;
    // Gating with resetn keeps the bus quiet while reset is held.
    bus.req     = w_sel_req & ~w_full & resetn;
    bus.wr      = (w_sel == OWN_DATA) ? data.wr    : inst.wr;
    bus.size    = (w_sel == OWN_DATA) ? data.size  : inst.size;
    bus.addr    = (w_sel == OWN_DATA) ? data.addr  : inst.addr;
    bus.wdata   = (w_sel == OWN_DATA) ? data.wdata : inst.wdata;
    w_accept    = bus.req & bus.addrok;
    inst.addrok = w_accept & (w_sel == OWN_INST);
    data.addrok = w_accept & (w_sel == OWN_DATA);
    case (r_state)
      ST_UNLOCKED: if (bus.req && !bus.addrok) begin
        w_state_nxt = ST_LOCKED;
        w_owner_nxt = w_sel;
      end
      ST_LOCKED: if (bus.addrok) w_state_nxt = ST_UNLOCKED;
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  sram_like_arbiter_owner_fifo #(.DEPTH(OUTSTANDING), .PTR_W(PTR_W)) u_owner_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_accept),
    .i_din   (w_sel),
    .i_pop   (bus.dataok),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    inst.dataok = bus.dataok & ~w_empty & (w_head == OWN_INST);
    data.dataok = bus.dataok & ~w_empty & (w_head == OWN_DATA);
    inst.rdata  = bus.rdata;
    data.rdata  = bus.rdata;
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboarded bench: stimulus queues expected owners of accepted requests;
// a monitor pops them on each return and checks the address path every cycle.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;
  localparam int OUT = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sram_like_arbiter_if inst_if();
  sram_like_arbiter_if data_if();
  sram_like_arbiter_if bus_if();

  sram_like_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .resetn(resetn), .inst(inst_if), .data(data_if), .bus(bus_if)
  );

  int   n_checks = 0;
  int   n_errs   = 0;
  logic exp_q[$];             // owner of each accepted request, oldest first
  logic pend_v = 1'b0;        // slave has seen a request it has not accepted
  logic pend_who = 1'b0;
  logic exp_bus_req = 1'b0;
  logic exp_sel = 1'b0;
  logic last_acc = 1'b0;
  logic last_who = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: slave drives its response, the model predicts the grant,
  // and acceptance is recorded once the edge has passed.
  task automatic cycle(input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    bus_if.addrok = aok;
    bus_if.dataok = dok;
    bus_if.rdata  = rd;
    exp_sel     = pend_v ? pend_who : (data_if.req ? 1'b1 : 1'b0);
    exp_bus_req = resetn && (exp_sel ? data_if.req : inst_if.req) && (exp_q.size() < OUT);
    @(posedge clk); #1;
    last_acc = exp_bus_req && aok;
    last_who = exp_sel;
    if (last_acc) exp_q.push_back(exp_sel);
    if (!resetn || aok) pend_v = 1'b0;
    else if (exp_bus_req) begin
      pend_v   = 1'b1;
      pend_who = exp_sel;
    end
  endtask

  task automatic set_inst(input logic req, input logic [31:0] addr);
    inst_if.req   = req;
    inst_if.wr    = 1'b0;
    inst_if.size  = 2'd2;
    inst_if.addr  = addr;
    inst_if.wdata = $urandom();
  endtask

  task automatic set_data(input logic req, input logic wr, input logic [31:0] addr);
    data_if.req   = req;
    data_if.wr    = wr;
    data_if.size  = 2'($urandom_range(0, 2));
    data_if.addr  = addr;
    data_if.wdata = $urandom();
  endtask

  task automatic drain();
    set_inst(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3 * OUT && exp_q.size() > 0; k++) cycle(1'b0, 1'b1, $urandom());
    chk32("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: routes and data on every return, address path every cycle.
  initial begin : monitor
    logic dv, own;
    forever begin
      @(negedge clk); #2;
      dv  = bus_if.dataok && (exp_q.size() > 0);
      own = dv ? exp_q[0] : 1'b0;
      chk1("inst_dataok", inst_if.dataok, dv && !own);
      chk1("data_dataok", data_if.dataok, dv && own);
      if (inst_if.dataok) chk32("inst_rdata", inst_if.rdata, bus_if.rdata);
      if (data_if.dataok) chk32("data_rdata", data_if.rdata, bus_if.rdata);
      if (dv) void'(exp_q.pop_front());
      chk1("bus_req", bus_if.req, exp_bus_req);
      chk1("inst_addrok", inst_if.addrok, exp_bus_req && bus_if.addrok && !exp_sel);
      chk1("data_addrok", data_if.addrok, exp_bus_req && bus_if.addrok && exp_sel);
      if (exp_bus_req) begin
        chk32("bus_addr", bus_if.addr, exp_sel ? data_if.addr : inst_if.addr);
        chk32("bus_wdata", bus_if.wdata, exp_sel ? data_if.wdata : inst_if.wdata);
        chk1("bus_wr", bus_if.wr, exp_sel ? data_if.wr : inst_if.wr);
        chk32("bus_size", 32'(bus_if.size), 32'(exp_sel ? data_if.size : inst_if.size));
      end
    end
  end

  initial begin : stimulus
    resetn = 1'b0;
    set_inst(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 32'h0);
    bus_if.addrok = 1'b0;
    bus_if.dataok = 1'b0;
    bus_if.rdata  = '0;
    cycle(1'b0, 1'b0, 32'h0);
    set_inst(1'b1, 32'hbfc00000);         // requests under reset must stay gated
    cycle(1'b0, 1'b1, 32'h0);
    set_inst(1'b0, 32'h0);
    resetn = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);

    // Simultaneous requests: data first, then inst; returns in the same order.
    set_inst(1'b1, 32'hbfc00000);
    set_data(1'b1, 1'b0, 32'h80001000);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk1("both_first_is_data", last_acc && last_who, 1'b1);
    set_data(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    set_inst(1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h11111111);
    cycle(1'b0, 1'b1, 32'h22222222);

    // Lock: inst held through three addrok-less cycles while data arrives.
    set_inst(1'b1, 32'hbfc00000);
    cycle(1'b0, 1'b0, 32'h0);
    set_data(1'b1, 1'b1, 32'h80002000);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk1("lock_inst_accepted", last_acc && !last_who, 1'b1);
    set_inst(1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    drain();

    // Full: four inst requests outstanding blocks the fifth until a return.
    for (int i = 0; i < OUT; i++) begin
      set_inst(1'b1, 32'hbfc00000 + 32'(4 * i));
      cycle(1'b1, 1'b0, 32'h0);
    end
    set_inst(1'b1, 32'hbfc00010);
    cycle(1'b0, 1'b0, 32'h0);
    chk1("full_blocks_req", bus_if.req, 1'b0);
    cycle(1'b0, 1'b1, 32'h24080001);
    cycle(1'b1, 1'b0, 32'h0);
    chk1("full_reassert_acc", last_acc, 1'b1);
    drain();

    // Push and pop together at depth 2, across several pointer wraps.
    set_inst(1'b1, 32'hbfc00100);
    cycle(1'b1, 1'b0, 32'h0);
    set_inst(1'b0, 32'h0);
    set_data(1'b1, 1'b0, 32'h80003000);
    cycle(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      set_inst(i[0] == 1'b0, 32'hbfc00200 + 32'(4 * i));
      set_data(i[0] == 1'b1, 1'($urandom_range(0, 1)), 32'h80004000 + 32'(4 * i));
      cycle(1'b1, 1'b1, $urandom());
      chk32("pushpop_depth", 32'(exp_q.size()), 32'd2);
    end
    drain();

    // Spurious return on an empty queue.
    cycle(1'b0, 1'b1, 32'hdeadbeef);

    // Asynchronous reset with two outstanding and inst locked.
    set_inst(1'b1, 32'hbfc00300);
    cycle(1'b1, 1'b0, 32'h0);
    set_inst(1'b1, 32'hbfc00304);
    cycle(1'b1, 1'b0, 32'h0);
    set_inst(1'b1, 32'hbfc00308);
    cycle(1'b0, 1'b0, 32'h0);
    @(negedge clk); #3;
    resetn = 1'b0;
    #1;
    chk1("async_rst_bus_req", bus_if.req, 1'b0);
    chk1("async_rst_inst_addrok", inst_if.addrok, 1'b0);
    exp_q.delete();
    pend_v      = 1'b0;
    exp_bus_req = 1'b0;
    set_inst(1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    resetn = 1'b1;
    cycle(1'b0, 1'b1, 32'h33333333);
    cycle(1'b0, 1'b1, 32'h44444444);

    // Randomized traffic; masters hold each request until it is accepted.
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom());
      if ((last_acc && !last_who) || !inst_if.req)
        set_inst($urandom_range(0, 1) == 1, $urandom());
      if ((last_acc && last_who) || !data_if.req)
        set_data($urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)), $urandom());
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
